paralelo_serial: RTL and testbench

Byte-to-serial transmitter of the PHY link; it is the transmit end paired with the serial-to-parallel receiver. It accepts bytes through a valid/ready handshake into a small FIFO and serializes them MSB-first, one bit per clk_32f cycle, in 8-cycle byte slots. After reset it sends a fixed preamble of 0xBC comma bytes so the receiver can align and go active. Whenever no data byte is queued, it fills the slot with an idle 0xBC comma.

---
 rtl/paralelo_serial_if.sv | 14 +
 rtl/paralelo_serial.sv | 147 ++++++++++++++
 tb/tb_paralelo_serial.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/paralelo_serial_if.sv
// Byte handshake between an upstream producer and the paralelo_serial
// transmitter.
//   data_in   : byte offered by the producer
//   valid_in  : data_in holds a byte
//   ready_out : transmitter FIFO can take a byte this cycle
// A byte moves on a clock edge where valid_in && ready_out.
interface paralelo_serial_if;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;

    modport master (output data_in, output valid_in, input ready_out);
    modport slave  (input data_in, input valid_in, output ready_out);
endinterface

// File: rtl/paralelo_serial.sv
// Byte-to-serial transmitter for the PHY link. Bytes are queued through
// a valid/ready handshake and shifted out MSB-first in 8-cycle slots.
// After reset a preamble of SYNC_BC comma bytes is sent. Empty slots are
// filled with the comma byte.
//
// State table:
//   SYNC   | preamble running, every slot carries IDLE_BYTE
//   ACTIVE | slots carry queued bytes, or IDLE_BYTE when the FIFO is empty
//
// Ports:
//   clk_32f    : bit clock, all logic on posedge
//   reset      : synchronous, active-high
//   link       : byte handshake (data_in / valid_in / ready_out)
//   data_out   : registered serial bit, MSB first
//   active_out : registered, preamble finished
//   idle_out   : registered, byte currently on data_out is filler/preamble
module paralelo_serial #(
    parameter int         SYNC_BC    = 4,
    parameter logic [7:0] IDLE_BYTE  = 8'hBC,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic               clk_32f,
    input  logic               reset,
    paralelo_serial_if.slave   link,
    output logic               data_out,
    output logic               active_out,
    output logic               idle_out
);

    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic {SYNC, ACTIVE} state_t;

    state_t       state;
    state_t       state_nx;

    logic [7:0]   sh;
    logic         sh_idle;
    logic [2:0]   bit_cnt;
    logic [3:0]   bc_cnt;

    logic [7:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]  count;

    logic         boundary;
    logic         push;
    logic         pop;
    logic [7:0]   load_byte;

    assign boundary       = (bit_cnt == 3'd7);
    assign link.ready_out = !reset && (count < (PW+1)'(FIFO_DEPTH));
    assign push           = link.valid_in && link.ready_out;
    // The head is taken only at a slot boundary while ACTIVE; a byte written
    // on that same edge is not yet visible in count, so there is no bypass.
    assign pop            = boundary && (state == ACTIVE) && (count != '0);
    assign load_byte      = pop ? mem[rd_ptr] : IDLE_BYTE;

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state <= SYNC;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            SYNC: begin
                // Slot 1 is preloaded, so the boundary loading comma number
                // SYNC_BC is the one seen while bc_cnt == SYNC_BC-1.
                if (boundary && (bc_cnt == 4'(SYNC_BC - 1))) begin
                    state_nx = ACTIVE;
                end
            end
            ACTIVE: begin
                state_nx = ACTIVE;
            end
            default: begin
                state_nx = SYNC;
            end
        endcase
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            bc_cnt <= 4'd1;
        end else if ((state == SYNC) && boundary) begin
            bc_cnt <= bc_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            sh         <= IDLE_BYTE;
            sh_idle    <= 1'b1;
            bit_cnt    <= 3'd0;
            data_out   <= 1'b0;
            idle_out   <= 1'b0;
            active_out <= 1'b0;
        end else begin
            data_out   <= sh[7];
            active_out <= (state_nx == ACTIVE);
            // The slot flag follows the byte and surfaces with its first bit.
            if (bit_cnt == 3'd0) begin
                idle_out <= sh_idle;
            end
            if (boundary) begin
                sh      <= load_byte;
                sh_idle <= !pop;
                bit_cnt <= 3'd0;
            end else begin
                sh      <= {sh[6:0], 1'b0};
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clk_32f) begin
        if (push) begin
            mem[wr_ptr] <= link.data_in;
        end
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_paralelo_serial.sv
// Scoreboard bench for paralelo_serial. The stimulus side records every
// accepted byte with the edge number it was taken on; the monitor rebuilds
// each 8-bit slot from data_out and compares it with the slot the link
// rules predict: preamble commas first, then the oldest byte pushed strictly
// before the slot's boundary edge, otherwise a filler comma.
module tb_paralelo_serial;

    localparam int         SYNC_BC    = 4;
    localparam logic [7:0] IDLE_BYTE  = 8'hBC;
    localparam int         FIFO_DEPTH = 4;

    typedef struct {
        logic [7:0] b;
        int         e;
    } ent_t;

    logic clk_32f = 1'b0;
    logic reset   = 1'b1;
    logic data_out, active_out, idle_out;

    paralelo_serial_if link ();

    paralelo_serial #(
        .SYNC_BC    (SYNC_BC),
        .IDLE_BYTE  (IDLE_BYTE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_32f    (clk_32f),
        .reset      (reset),
        .link       (link.slave),
        .data_out   (data_out),
        .active_out (active_out),
        .idle_out   (idle_out)
    );

    always #5 clk_32f = ~clk_32f;

    int   checks   = 0;
    int   failures = 0;
    int   edge_cnt = 0;
    bit   rst_seen = 1'b0;
    ent_t exp_q[$];

    task automatic check(input string name, input bit ok, input int act, input int req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s at edge %0d: actual=0x%0h required=0x%0h", name, edge_cnt, act, req);
        end
    endtask

    // Edge numbering restarts at 1 on the first posedge with reset low.
    always @(posedge clk_32f) begin
        if (reset) begin
            edge_cnt = 0;
            rst_seen = 1'b1;
        end else begin
            edge_cnt = edge_cnt + 1;
        end
    end

    // Monitor
    logic [7:0] cur_byte;
    bit         cur_idle;
    logic [7:0] acc;
    bit         idle_bad;

    always @(negedge clk_32f) begin
        int n;
        int occ;
        if (edge_cnt == 0) begin
            if (rst_seen) begin
                check("reset_outputs", {data_out, active_out, idle_out} == 3'b000,
                      {data_out, active_out, idle_out}, 0);
                check("reset_ready", link.ready_out == !reset, link.ready_out, !reset);
            end
            cur_byte = IDLE_BYTE;
            cur_idle = 1'b1;
            acc      = '0;
            idle_bad = 1'b0;
        end else begin
            acc = {acc[6:0], data_out};
            if (idle_out != cur_idle) idle_bad = 1'b1;
            check("active_out", active_out == (edge_cnt >= 8 * (SYNC_BC - 1)),
                  active_out, edge_cnt >= 8 * (SYNC_BC - 1));
            if ((edge_cnt % 8) == 0) begin
                check("slot_byte", acc == cur_byte, acc, cur_byte);
                check("slot_idle_flag", !idle_bad, !cur_idle, cur_idle);
                n = edge_cnt / 8;
                if (n < SYNC_BC) begin
                    cur_byte = IDLE_BYTE;
                    cur_idle = 1'b1;
                end else if (exp_q.size() > 0 && exp_q[0].e < edge_cnt) begin
                    cur_byte = exp_q[0].b;
                    cur_idle = 1'b0;
                    void'(exp_q.pop_front());
                end else begin
                    cur_byte = IDLE_BYTE;
                    cur_idle = 1'b1;
                end
                idle_bad = 1'b0;
            end
            occ = 0;
            foreach (exp_q[i]) if (exp_q[i].e <= edge_cnt) occ++;
            check("ready_out", link.ready_out == (!reset && occ < FIFO_DEPTH),
                  link.ready_out, !reset && occ < FIFO_DEPTH);
        end
    end

    // Stimulus (always called at a negedge)
    task automatic do_reset(input int ncyc);
        reset         = 1'b1;
        link.valid_in = 1'b0;
        repeat (ncyc) @(negedge clk_32f);
        exp_q.delete();
        reset = 1'b0;
    endtask

    task automatic wait_until(input int e);
        while (edge_cnt < e) @(negedge clk_32f);
    endtask

    task automatic offer(input logic [7:0] b, input int timeout);
        link.valid_in = 1'b1;
        link.data_in  = b;
        for (int i = 0; i < timeout; i++) begin
            if (link.ready_out) begin
                exp_q.push_back('{b: b, e: edge_cnt + 1});
                @(negedge clk_32f);
                link.valid_in = 1'b0;
                return;
            end
            @(negedge clk_32f);
        end
        link.valid_in = 1'b0;
        check("push_timeout", 1'b0, 0, 1);
    endtask

    initial begin
        link.valid_in = 1'b0;
        link.data_in  = 8'h00;
        @(negedge clk_32f);

        // Idle stream after reset
        do_reset(2);
        repeat (200) @(negedge clk_32f);

        // Single byte at edge 40
        do_reset(2);
        wait_until(39);
        offer(8'hA5, 50);
        repeat (40) @(negedge clk_32f);

        // Burst with backpressure
        do_reset(2);
        wait_until(39);
        for (int b = 1; b <= 6; b++) offer(8'(b), 100);
        repeat (80) @(negedge clk_32f);

        // Pushes during the preamble, then a payload comma
        do_reset(2);
        wait_until(1);
        offer(8'h11, 50);
        offer(8'h22, 50);
        repeat (60) @(negedge clk_32f);
        offer(IDLE_BYTE, 50);
        repeat (30) @(negedge clk_32f);

        // Reset in the middle of a data slot with bytes queued
        do_reset(2);
        wait_until(39);
        offer(8'h5A, 50);
        offer(8'hC3, 50);
        offer(8'h7E, 50);
        wait_until(52);
        do_reset(2);
        repeat (80) @(negedge clk_32f);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            link.data_in  = 8'($urandom);
            link.valid_in = ($urandom_range(0, 99) < 35);
            if (link.valid_in && link.ready_out)
                exp_q.push_back('{b: link.data_in, e: edge_cnt + 1});
            @(negedge clk_32f);
        end
        link.valid_in = 1'b0;
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk_32f);
        check("drain", exp_q.size() == 0, exp_q.size(), 0);
        repeat (16) @(negedge clk_32f);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
